// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and FSM encoding for the sequential CLA adder
// Purpose: nibble width and state encoding used by cla_seq_adder.
// Ports: none (package).
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pre_4_adder.sv
// rtl/pre_4_adder.sv - combinational 4-bit carry-lookahead adder slice
// Purpose: one nibble of add with carry-in, carries generated in parallel.
// Ports:
//   A, B  in  4  nibble operands
//   c0    in  1  carry in
//   F     out 4  nibble sum
//   c4    out 1  carry out of bit 3
module pre_4_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       c0,
    output logic [3:0] F,
    output logic       c4
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;

    assign g = A & B;
    assign p = A ^ B;

    // Flattened lookahead terms: every carry depends only on g, p and c0.
    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

    assign F = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle add/subtract, one CLA nibble per cycle, LSB first
// Purpose: latches an operand pair on start/ready, walks the nibbles through a single
//          pre_4_adder slice with a registered ripple carry, pulses done when finished.
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset
//   start  in   1  request, accepted only while ready
//   sub    in   1  0: F=A+B, 1: F=A-B; sampled with start
//   A, B   in   W  operands; sampled with start
//   ready  out  1  idle or done, start can be accepted
//   busy   out  1  operation in progress
//   done   out  1  one-cycle pulse, F/cout/ovf valid
//   F      out  W  result, held until next accepted start
//   cout   out  1  carry out of MSB (sub: 1 = no borrow)
//   ovf    out  1  signed overflow
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int N_NIB = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [NIB_W*N_NIB-1:0] A,
    input  logic [NIB_W*N_NIB-1:0] B,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [NIB_W*N_NIB-1:0] F,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W     = NIB_W * N_NIB;
    localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     a_r;
    logic [W-1:0]     bx_r;
    logic [W-1:0]     f_r;
    logic             cout_r;
    logic             ovf_r;

    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] sum;
    logic             c4;
    logic             c3_msb;
    logic [W-1:0]     f_next;

    // Operand nibble select for the current idx.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < N_NIB; i++) begin
            if (idx == IDX_W'(i)) begin
                a_nib = a_r[NIB_W*i +: NIB_W];
                b_nib = bx_r[NIB_W*i +: NIB_W];
            end
        end
    end

    pre_4_adder u_slice (
        .A  (a_nib),
        .B  (b_nib),
        .c0 (carry),
        .F  (sum),
        .c4 (c4)
    );

    // Result with the current nibble's sum merged in; kept apart from the
    // operand mux so the slice is not part of a combinational cycle.
    always_comb begin
        f_next = f_r;
        for (int i = 0; i < N_NIB; i++) begin
            if (idx == IDX_W'(i)) begin
                f_next[NIB_W*i +: NIB_W] = sum;
            end
        end
    end

    // Carry into the MSB recovered from the MSB sum bit; only meaningful on the last nibble.
    assign c3_msb = a_r[W-1] ^ bx_r[W-1] ^ sum[NIB_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            bx_r   <= '0;
            f_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Subtract as A + ~B + 1: invert B here, the +1 enters as carry-in.
                        a_r   <= A;
                        bx_r  <= B ^ {W{sub}};
                        carry <= sub;
                        idx   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    f_r   <= f_next;
                    carry <= c4;
                    if (idx == LAST_IDX) begin
                        cout_r <= c4;
                        ovf_r  <= c3_msb ^ c4;
                        idx    <= '0;
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready = (state == ST_IDLE) || (state == ST_DONE);
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);
    assign F     = f_r;
    assign cout  = cout_r;
    assign ovf   = ovf_r;

endmodule
